// File: rtl/intif_pkg.sv
// Shared definitions for the interrupt interface: FSM states, the mip and
// mstatus bit positions, the machine-interrupt mcause codes, and the fixed
// priority arbiter.
package intif_pkg;

    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } intif_state_t;

    localparam int MIP_MEIP    = 11;
    localparam int MIP_MTIP    = 7;
    localparam int MIP_MSIP    = 3;
    localparam int MSTATUS_MIE = 3;

    localparam logic [REG_DATA_WIDTH-1:0] MCAUSE_MEI = 32'h8000000B;
    localparam logic [REG_DATA_WIDTH-1:0] MCAUSE_MSI = 32'h80000003;
    localparam logic [REG_DATA_WIDTH-1:0] MCAUSE_MTI = 32'h80000007;

    // Fixed priority MEI > MSI > MTI. Returns 0 when nothing is enabled.
    function automatic logic [REG_DATA_WIDTH-1:0] pick_mcause(
        input logic [REG_DATA_WIDTH-1:0] en
    );
        if (en[MIP_MEIP])      return MCAUSE_MEI;
        else if (en[MIP_MSIP]) return MCAUSE_MSI;
        else if (en[MIP_MTIP]) return MCAUSE_MTI;
        else                   return '0;
    endfunction

endpackage

// File: rtl/intif_sync.sv
// intif_sync: STAGES-deep flop chain bringing one asynchronous level into
// the clk domain.
//   clk    core clock
//   rst    synchronous active-high reset, clears every stage
//   d_i    asynchronous input level
//   q_o    synchronised level (last stage)
module intif_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    generate
        if (STAGES == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (rst) chain_q <= '0;
                else     chain_q <= d_i;
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (rst) chain_q <= '0;
                else     chain_q <= {chain_q[STAGES-2:0], d_i};
            end
        end
    endgenerate

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/interrupt_interface.sv
// interrupt_interface: synchronises the machine-level interrupt lines into a
// registered mip image, qualifies it with mie and mstatus.MIE, and presents a
// held interrupt request plus mcause to commit. After commit acknowledges,
// a short holdoff gives csrfile time to apply the mstatus write before the
// next arbitration.
//   clk, rst                          clock, synchronous active-high reset
//   all_intif_int_{ext,timer,software}_req  async interrupt levels
//   csrf_all_mie_data                 current mie
//   csrf_all_mstatus_data             current mstatus (only MIE is used)
//   intif_csrf_mip_data               registered mip image
//   intif_commit_has_interrupt        registered request to commit
//   intif_commit_mcause_data          registered mcause of the request
//   commit_intif_ack                  one-cycle pulse: trap taken
module interrupt_interface
    import intif_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      all_intif_int_ext_req,
    input  logic                      all_intif_int_timer_req,
    input  logic                      all_intif_int_software_req,
    input  logic [REG_DATA_WIDTH-1:0] csrf_all_mie_data,
    input  logic [REG_DATA_WIDTH-1:0] csrf_all_mstatus_data,
    output logic [REG_DATA_WIDTH-1:0] intif_csrf_mip_data,
    output logic                      intif_commit_has_interrupt,
    output logic [REG_DATA_WIDTH-1:0] intif_commit_mcause_data,
    input  logic                      commit_intif_ack
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    logic ext_s, timer_s, sw_s;

    intif_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
        .clk(clk), .rst(rst), .d_i(all_intif_int_ext_req), .q_o(ext_s)
    );
    intif_sync #(.STAGES(SYNC_STAGES)) u_sync_timer (
        .clk(clk), .rst(rst), .d_i(all_intif_int_timer_req), .q_o(timer_s)
    );
    intif_sync #(.STAGES(SYNC_STAGES)) u_sync_sw (
        .clk(clk), .rst(rst), .d_i(all_intif_int_software_req), .q_o(sw_s)
    );

    logic [REG_DATA_WIDTH-1:0] mip_d, mip_q;
    logic [REG_DATA_WIDTH-1:0] en;
    intif_state_t              state_d, state_q;
    logic                      has_d, has_q;
    logic [REG_DATA_WIDTH-1:0] mcause_d, mcause_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q;

    always_comb begin
        mip_d           = '0;
        mip_d[MIP_MEIP] = ext_s;
        mip_d[MIP_MTIP] = timer_s;
        mip_d[MIP_MSIP] = sw_s;
    end

    assign en = mip_q & csrf_all_mie_data
              & {REG_DATA_WIDTH{csrf_all_mstatus_data[MSTATUS_MIE]}};

    // The low five bits of each mcause code equal the mip bit position of
    // its source, so the latched mcause directly indexes the enable vector
    // to detect withdrawal.
    always_comb begin
        state_d  = state_q;
        has_d    = has_q;
        mcause_d = mcause_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|en) begin
                    state_d  = REQ;
                    has_d    = 1'b1;
                    mcause_d = pick_mcause(en);
                end
            end
            REQ: begin
                if (commit_intif_ack) begin
                    state_d  = HOLDOFF;
                    has_d    = 1'b0;
                    mcause_d = '0;
                    cnt_d    = CNT_W'(HOLDOFF_CYCLES - 1);
                end else if (!en[mcause_q[4:0]]) begin
                    state_d  = IDLE;
                    has_d    = 1'b0;
                    mcause_d = '0;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d  = IDLE;
                has_d    = 1'b0;
                mcause_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mip_q    <= '0;
            state_q  <= IDLE;
            has_q    <= 1'b0;
            mcause_q <= '0;
            cnt_q    <= '0;
        end else begin
            mip_q    <= mip_d;
            state_q  <= state_d;
            has_q    <= has_d;
            mcause_q <= mcause_d;
            cnt_q    <= cnt_d;
        end
    end

    assign intif_csrf_mip_data        = mip_q;
    assign intif_commit_has_interrupt = has_q;
    assign intif_commit_mcause_data   = mcause_q;

    logic unused_mstatus;
    assign unused_mstatus = ^{csrf_all_mstatus_data[REG_DATA_WIDTH-1:MSTATUS_MIE+1],
                              csrf_all_mstatus_data[MSTATUS_MIE-1:0]};

endmodule

// File: tb/tb_interrupt_interface.sv
module tb_interrupt_interface;
    import intif_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext, timer, sw;
    logic [31:0] mie, mstatus;
    logic [31:0] mip;
    logic        has;
    logic [31:0] mcause;
    logic        ack;

    interrupt_interface #(.SYNC_STAGES(2), .HOLDOFF_CYCLES(2)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .all_intif_int_ext_req      (ext),
        .all_intif_int_timer_req    (timer),
        .all_intif_int_software_req (sw),
        .csrf_all_mie_data          (mie),
        .csrf_all_mstatus_data      (mstatus),
        .intif_csrf_mip_data        (mip),
        .intif_commit_has_interrupt (has),
        .intif_commit_mcause_data   (mcause),
        .commit_intif_ack           (ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic        has;
        logic [31:0] mcause;
        int          mip;    // -1: not checked
        int          state;  // -1: not checked
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   stim_done = 0;

    // Monitor: at each negedge, pop every expectation due by now and compare.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (has !== e.has) begin
                n_bad++;
                $display("FAIL %s has_interrupt: got %0b want %0b", e.name, has, e.has);
            end
            n_vec++;
            if (mcause !== e.mcause) begin
                n_bad++;
                $display("FAIL %s mcause: got %h want %h", e.name, mcause, e.mcause);
            end
            if (e.mip >= 0) begin
                n_vec++;
                if (mip !== 32'(e.mip)) begin
                    n_bad++;
                    $display("FAIL %s mip: got %h want %h", e.name, mip, 32'(e.mip));
                end
            end
            if (e.state >= 0) begin
                n_vec++;
                if (int'(dut.state_q) != e.state) begin
                    n_bad++;
                    $display("FAIL %s state: got %0d want %0d", e.name, int'(dut.state_q), e.state);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic h, input logic [31:0] mc,
                              input int mp, input int st);
        exp_t e;
        e.cyc = cyc; e.name = name; e.has = h; e.mcause = mc; e.mip = mp; e.state = st;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; ext = 0; timer = 0; sw = 0; ack = 0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0;
        ext = 1; timer = 1; sw = 1; mie = 32'h888; mstatus = 32'h8;
        #1;
        // Reset with all inputs high
        tick(1);
        expect_now("rst_1", 0, 0, 0, 0);
        tick(1);
        expect_now("rst_2", 0, 0, 0, 0);
        rst = 1'b0;
        tick(2);
        expect_now("rel_e2", 0, 0, 0, 0);
        tick(1);
        expect_now("rel_e3", 0, 0, 32'h888, 0);
        tick(1);
        expect_now("rel_e4", 1, 32'h8000000B, 32'h888, 1);

        // Gating by mstatus.MIE
        do_reset();
        ext = 1; mie = 32'h800; mstatus = 32'h0;
        tick(3);
        expect_now("gate_mip", 0, 0, 32'h800, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            expect_now("gate_hold", 0, 0, 32'h800, 0);
        end
        mstatus = 32'h8;
        tick(1);
        expect_now("gate_open", 1, 32'h8000000B, 32'h800, 1);

        // Priority with all three
        do_reset();
        ext = 1; timer = 1; sw = 1; mie = 32'h888; mstatus = 32'h8;
        tick(4);
        expect_now("prio_all", 1, 32'h8000000B, 32'h888, 1);

        // Lock, then ack and holdoff
        do_reset();
        timer = 1; mie = 32'h888; mstatus = 32'h8;
        tick(4);
        expect_now("lock_mti", 1, 32'h80000007, 32'h080, 1);
        ext = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            expect_now("lock_hold", 1, 32'h80000007, -1, 1);
        end
        ack = 1;
        tick(1);
        ack = 0;
        expect_now("ack_hold0", 0, 0, 32'h880, 2);
        tick(1);
        expect_now("ack_hold1", 0, 0, -1, 2);
        tick(1);
        expect_now("ack_idle", 0, 0, -1, 0);
        tick(1);
        expect_now("ack_rearb", 1, 32'h8000000B, -1, 1);

        // Withdrawal of MSI by mie
        do_reset();
        sw = 1; mie = 32'h888; mstatus = 32'h8;
        tick(4);
        expect_now("wd_req", 1, 32'h80000003, 32'h008, 1);
        mie = 32'h880;
        tick(1);
        expect_now("wd_drop", 0, 0, -1, 0);
        ack = 1;
        tick(1);
        ack = 0;
        expect_now("idle_ack", 0, 0, -1, 0);

        // Collision: withdrawal and ack together
        mie = 32'h888;
        tick(1);
        expect_now("col_req", 1, 32'h80000003, -1, 1);
        mie = 32'h880; ack = 1;
        tick(1);
        ack = 0;
        expect_now("col_hold", 0, 0, -1, 2);

        // Reset mid-HOLDOFF (counter at 1)
        mie = 32'h888;
        rst = 1;
        tick(1);
        expect_now("mid_rst", 0, 0, 0, 0);
        rst = 0;
        tick(2);
        expect_now("mid_e2", 0, 0, 0, 0);
        tick(1);
        expect_now("mid_e3", 0, 0, 32'h008, 0);
        tick(1);
        expect_now("mid_e4", 1, 32'h80000003, 32'h008, 1);

        stim_done = 1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
